msg_sched_ctrl: RTL and testbench



---
 rtl/sha256_pkg.sv | 51 +++++
 rtl/sched_sigma.sv | 16 +
 rtl/msg_sched_ctrl.sv | 124 ++++++++++++
 tb/tb_msg_sched_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types and constants for the miner hash core.
// Holds the schedule word type, round-index width, sequencer state encoding,
// and the round constants / initial hash value used by the compression core.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int ROUND_W = 6;
  localparam logic [ROUND_W-1:0] LAST_ROUND = 6'd63;

  // Depth of the rolling schedule window: W_t .. W_{t+15}
  localparam int WIN_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Round constants K0..K63 (consumed by the compression datapath)
  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value H0..H7
  localparam word_t H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Rotate a 32-bit word right by a constant amount
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sched_sigma.sv
// sched_sigma: the single small-sigma pair used by the message schedule.
// s0 operates on W_{t+1} (window slot 1), s1 on W_{t+14} (window slot 14).
// Purely combinational; one instance serves every round.
module sched_sigma
  import sha256_pkg::*;
(
  input  word_t w1,
  input  word_t w14,
  output word_t s0,
  output word_t s1
);

  assign s0 = rotr(w1, 7)   ^ rotr(w1, 18)  ^ (w1 >> 3);
  assign s1 = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);

endmodule

// File: rtl/msg_sched_ctrl.sv
// msg_sched_ctrl: iterative SHA-256 message-schedule sequencer.
// Loads one 512-bit block, then issues W0..W(ROUNDS-1) one round per cycle
// from a 16-word rolling window, then pulses blk_done for one cycle.
// Optional feature macro: SCHED_BACKPRESSURE_EN adds a round_ready input so
// the compression core can stall the stream; without it rounds advance
// every RUN cycle.
module msg_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [511:0]       blk_data,
  input  logic               blk_valid,
  output logic               blk_ready,
  output logic               round_valid,
`ifdef SCHED_BACKPRESSURE_EN
  input  logic               round_ready,
`endif
  output logic [ROUND_W-1:0] round_idx,
  output word_t              w_t,
  output logic               round_last,
  output logic               blk_done
);

  // Index of the final round issued for a block
  localparam logic [ROUND_W-1:0] LAST_T = ROUND_W'(ROUNDS - 1);

  sched_state_t       state_q;
  sched_state_t       state_d;
  logic [ROUND_W-1:0] t_q;
  word_t              win_q [WIN_DEPTH];

  logic  load;
  logic  consume;
  word_t sig0;
  word_t sig1;
  word_t next_word;

  // A block is taken only while idle; offers at other times simply wait
  assign load = (state_q == IDLE) && blk_valid;

`ifdef SCHED_BACKPRESSURE_EN
  assign consume = (state_q == RUN) && round_ready;
`else
  assign consume = (state_q == RUN);
`endif

  sched_sigma u_sigma (
    .w1  (win_q[1]),
    .w14 (win_q[14]),
    .s0  (sig0),
    .s1  (sig1)
  );

  // W_{t+16}; computed on every shift, the tail values past round 47 are never issued
  assign next_word = sig1 + win_q[9] + sig0 + win_q[0];

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode, all from registered state only
  always_comb begin
    state_d     = state_q;
    blk_ready   = 1'b0;
    round_valid = 1'b0;
    blk_done    = 1'b0;
    round_last  = 1'b0;
    round_idx   = t_q;
    w_t         = '0;
    unique case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        round_valid = 1'b1;
        w_t         = win_q[0];
        round_last  = (t_q == LAST_T);
        if (consume && (t_q == LAST_T)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        blk_done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Rolling window and round counter: load on accept, shift on each consumed round
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      t_q <= '0;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else if (load) begin
      t_q <= '0;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= blk_data[511 - 32*i -: 32];
      end
    end else if (consume) begin
      for (int i = 0; i < WIN_DEPTH - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[WIN_DEPTH-1] <= next_word;
      t_q <= (t_q == LAST_T) ? '0 : t_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_msg_sched_ctrl.sv
// tb_msg_sched_ctrl: scoreboard bench for msg_sched_ctrl.
// Accepted blocks are expanded by a textbook SHA-256 schedule model into a
// queue of expected rounds; a negedge monitor compares the DUT against the
// queue head every cycle and pops on each consumed round.
module tb_msg_sched_ctrl;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] ONES_BLK = {512{1'b1}};

  typedef struct {
    int          idx;
    logic [31:0] w;
    bit          abc;
  } exp_t;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         round_valid;
  logic         round_ready = 1'b1;
  logic [5:0]   round_idx;
  logic [31:0]  w_t;
  logic         round_last;
  logic         blk_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t        q[$];
  logic [31:0] ws [64];
  bit          started = 0;
  bit          after_reset = 0;
  bit          done_now = 0;
  bit          held = 0;
  bit          have_prev = 0;
  int          load_edge = 0;
  int          stall_cnt = 0;

`ifdef SCHED_BACKPRESSURE_EN
  int rr_mode = 0;
`endif

  msg_sched_ctrl #(.ROUNDS(64)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .blk_data    (blk_data),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .round_valid (round_valid),
`ifdef SCHED_BACKPRESSURE_EN
    .round_ready (round_ready),
`endif
    .round_idx   (round_idx),
    .w_t         (w_t),
    .round_last  (round_last),
    .blk_done    (blk_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge counter used for latency checks
  always @(posedge sys_clk) cyc = cyc + 1;

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-word schedule in textbook form, sums reduced mod 2^32 explicitly
  function automatic void build_schedule(input logic [511:0] blk, output logic [31:0] w [64]);
    for (int j = 0; j < 16; j++) begin
      w[j] = blk[511 - 32*j -: 32];
    end
    for (int j = 16; j < 64; j++) begin
      logic [63:0] sum;
      sum = 64'(ssig1(w[j-2])) + 64'(w[j-7]) + 64'(ssig0(w[j-15])) + 64'(w[j-16]);
      w[j] = 32'(sum % 64'h1_0000_0000);
    end
  endfunction

  function automatic bit known_answer(input int idx, output logic [31:0] v);
    v = '0;
    case (idx)
      0:  v = 32'h61626380;
      15: v = 32'h00000018;
      16: v = 32'h61626380;
      17: v = 32'h000F0000;
      63: v = 32'h12B1EDEB;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and scoreboard: compare outputs with expectation, then advance the model
  always @(negedge sys_clk) begin
    exp_t        e;
    logic [31:0] kv;
    bit          done_next;
    if (started) begin
      if (after_reset) begin
        check("reset_blk_ready", blk_ready, 1);
        check("reset_round_valid", round_valid, 0);
        check("reset_round_idx", round_idx, 0);
        check("reset_w_t", w_t, 0);
        check("reset_round_last", round_last, 0);
        check("reset_blk_done", blk_done, 0);
      end else if (q.size() != 0) begin
        e = q[0];
        check("round_valid", round_valid, 1);
        check("round_idx", round_idx, e.idx);
        check("w_t", w_t, e.w);
        check("round_last", round_last, (e.idx == 63) ? 1 : 0);
        check("blk_ready_busy", blk_ready, 0);
        check("blk_done_busy", blk_done, 0);
        if (e.abc && known_answer(e.idx, kv)) begin
          check("abc_known_word", w_t, kv);
        end
      end else if (done_now) begin
        check("blk_done", blk_done, 1);
        check("round_valid_done", round_valid, 0);
        check("round_last_done", round_last, 0);
        check("blk_ready_done", blk_ready, 0);
        check("done_latency", cyc - load_edge, 64 + stall_cnt);
      end else begin
        check("blk_ready_idle", blk_ready, 1);
        check("round_valid_idle", round_valid, 0);
        check("round_last_idle", round_last, 0);
        check("blk_done_idle", blk_done, 0);
      end
    end

    if (!blk_valid) held = 0;
    if (rst) begin
      q.delete();
      started     = 1;
      after_reset = 1;
      done_now    = 0;
      held        = 0;
      have_prev   = 0;
      stall_cnt   = 0;
    end else if (started) begin
      after_reset = 0;
      done_next   = 0;
      if (q.size() != 0) begin
        if (round_ready) begin
          if (q[0].idx == 63) done_next = 1;
          void'(q.pop_front());
        end else begin
          stall_cnt++;
        end
      end else if (!done_now && blk_valid) begin
        if (held && have_prev) begin
          check("b2b_reload_edge", (cyc + 1) - load_edge, 66 + stall_cnt);
        end
        build_schedule(blk_data, ws);
        for (int i = 0; i < 64; i++) begin
          q.push_back('{idx: i, w: ws[i], abc: (blk_data == ABC_BLK)});
        end
        load_edge = cyc + 1;
        have_prev = 1;
        held      = 1;
        stall_cnt = 0;
      end
      done_now = done_next;
    end
  end

`ifdef SCHED_BACKPRESSURE_EN
  // round_ready driver: always high, random, or forced low
  always @(posedge sys_clk) begin
    #2;
    case (rr_mode)
      0:       round_ready = 1'b1;
      1:       round_ready = ($urandom_range(0, 3) != 0);
      default: round_ready = 1'b0;
    endcase
  end
`endif

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!blk_ready) begin
      n++;
      if (n > 400) begin
        $display("[TB] FAIL wait_ready: blk_ready still 0 after %0d cycles, expected 1", n);
        $fatal(1, "[TB] timeout waiting for blk_ready");
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!blk_done) begin
      n++;
      if (n > 1000) begin
        $display("[TB] FAIL wait_done: blk_done still 0 after %0d cycles, expected 1", n);
        $fatal(1, "[TB] timeout waiting for blk_done");
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic wait_idx(input int idx);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!(round_valid && round_idx == 6'(idx))) begin
      n++;
      if (n > 1000) begin
        $display("[TB] FAIL wait_idx: round %0d never presented, got idx %0d", idx, round_idx);
        $fatal(1, "[TB] timeout waiting for round index");
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic offer_block(input logic [511:0] data);
    @(posedge sys_clk); #2;
    blk_data  = data;
    blk_valid = 1'b1;
    wait_ready();
    @(posedge sys_clk); #2;
    blk_valid = 1'b0;
  endtask

  function automatic logic [511:0] random_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) begin
      b[511 - 32*i -: 32] = $urandom;
    end
    return b;
  endfunction

  // Main stimulus sequence
  initial begin
    logic [511:0] b1;
    logic [511:0] b2;
    rst       = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;
    repeat (3) @(posedge sys_clk);
    #2 rst = 1'b0;

    // "abc" block, no stalls
    offer_block(ABC_BLK);
    wait_done();

`ifdef SCHED_BACKPRESSURE_EN
    // Five-cycle stall while round 20 is presented
    offer_block(ABC_BLK);
    wait_idx(19);
    @(posedge sys_clk); #1 rr_mode = 2;
    repeat (5) @(posedge sys_clk);
    #1 rr_mode = 0;
    wait_done();
`endif

    // blk_valid held high across two blocks
    b1 = random_block();
    b2 = random_block();
    @(posedge sys_clk); #2;
    blk_data  = b1;
    blk_valid = 1'b1;
    wait_ready();
    @(posedge sys_clk); #2;
    blk_data = b2;
    wait_ready();
    @(posedge sys_clk); #2;
    blk_valid = 1'b0;
    wait_done();

    // Reset mid-block at round 30, then reload "abc"
    offer_block(ABC_BLK);
    wait_idx(29);
    @(posedge sys_clk); #2 rst = 1'b1;
    @(posedge sys_clk); #2 rst = 1'b0;
    offer_block(ABC_BLK);
    wait_done();

    // All-ones block exercises carry wrap-around
    offer_block(ONES_BLK);
    wait_done();

`ifdef SCHED_BACKPRESSURE_EN
    rr_mode = 1;
`endif
    // Random blocks with random gaps
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      offer_block(random_block());
      wait_done();
    end

    repeat (3) @(negedge sys_clk);
    if (q.size() != 0) begin
      $display("[TB] FAIL drain: %0d rounds never issued, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
